dict_loader: RTL and testbench



---
 rtl/dict_loader_pkg.sv | 33 +++
 rtl/dict_loader_req.sv | 34 +++
 rtl/dict_loader.sv | 134 +++++++++++++
 tb/tb_dict_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dict_loader_pkg.sv
// Shared types and constants for the boot-time dictionary loader.
// The optional checksum phase is enabled with DICT_LOADER_CHECKSUM_EN.
package dict_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_F1, S_F2, S_F3, S_CHK, S_DONE
  } state_t;

  localparam int CNT_W  = 9;
  localparam int C1_LSB = 0;
  localparam int C2_LSB = 9;
  localparam int C3_LSB = 18;

  localparam logic [31:0] DICT_BASE_ADDR_DEF = 32'h0000_F000;

  typedef struct packed {
    logic        go;
    logic [31:0] addr;
  } rd_req_t;

  typedef struct packed {
    logic        done;
    logic [31:0] data;
  } rd_rsp_t;

  // Limit a header count to the 2^key_w entries the dictionary can hold.
  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c, input int key_w);
    logic [CNT_W:0] cap;
    cap = {{CNT_W{1'b0}}, 1'b1} << key_w;
    return ({1'b0, c} > cap) ? cap[CNT_W-1:0] : c;
  endfunction

endpackage

// File: rtl/dict_loader_req.sv
// Single-word memory reader: a go pulse launches one request, done pulses
// the cycle after ready with the captured word while valid is held low.
module dict_loader_req
  import dict_loader_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  rd_req_t     req,
  output rd_rsp_t     rsp,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic [31:0] mem_req_rdata
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      rsp           <= '0;
    end else begin
      rsp.done <= 1'b0;
      if (mem_req_valid && mem_req_ready) begin
        mem_req_valid <= 1'b0;
        rsp.done      <= 1'b1;
        rsp.data      <= mem_req_rdata;
      end else if (req.go && !mem_req_valid) begin
        mem_req_valid <= 1'b1;
        mem_req_addr  <= req.addr;
      end
    end
  end

endmodule

// File: rtl/dict_loader.sv
// Boot-time dictionary loader: header, F1/F2/F3 entries, optional checksum
// word (DICT_LOADER_CHECKSUM_EN), streamed into the dictionary write ports.
module dict_loader
  import dict_loader_pkg::*;
#(
  parameter int          FIELD1_VAL_WIDTH = 7,
  parameter int          FIELD2_VAL_WIDTH = 10,
  parameter int          FIELD3_VAL_WIDTH = 15,
  parameter int          FIELD1_KEY_WIDTH = 3,
  parameter int          FIELD2_KEY_WIDTH = 5,
  parameter int          FIELD3_KEY_WIDTH = 8,
  parameter logic [31:0] DICT_BASE_ADDR   = DICT_BASE_ADDR_DEF
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [31:0]                 mem_req_addr,
  input  logic [31:0]                 mem_req_rdata,
  output logic                        dict1_write_enable,
  output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  output logic                        dict2_write_enable,
  output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  output logic                        dict3_write_enable,
  output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
  output logic                        busy,
  output logic                        load_done
`ifdef DICT_LOADER_CHECKSUM_EN
  , output logic                      load_error
`endif
);

  state_t           state, nxt;
  logic [CNT_W-1:0] rem, rem_n, cnt2, cnt3, n1, n2, n3;
  logic [31:0]      addr_q;
  rd_req_t          req;
  rd_rsp_t          rsp;
  logic             hdr_unused;

  dict_loader_req u_req (
    .clk(clk), .resetn(resetn), .req(req), .rsp(rsp),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rdata(mem_req_rdata)
  );

  assign hdr_unused = ^rsp.data[31:27];

  // Phase selection skips empty phases; later counts come fresh from the
  // header word while in HDR, otherwise from the latched copies.
  always_comb begin
    nxt      = state;
    rem_n    = rem;
    req.go   = 1'b0;
    req.addr = addr_q;
    n1 = clamp_cnt(rsp.data[C1_LSB +: CNT_W], FIELD1_KEY_WIDTH);
    n2 = (state == S_HDR) ? clamp_cnt(rsp.data[C2_LSB +: CNT_W], FIELD2_KEY_WIDTH) : cnt2;
    n3 = (state == S_HDR) ? clamp_cnt(rsp.data[C3_LSB +: CNT_W], FIELD3_KEY_WIDTH) : cnt3;
    case (state)
      S_IDLE: if (start) begin
        nxt    = S_HDR;
        req.go = 1'b1;
      end
      S_HDR, S_F1, S_F2, S_F3: if (rsp.done) begin
        req.go = 1'b1;
        if (state != S_HDR && rem > CNT_W'(1)) begin
          rem_n = rem - CNT_W'(1);
        end else if (state == S_HDR && n1 != '0) begin
          nxt = S_F1; rem_n = n1;
        end else if ((state == S_HDR || state == S_F1) && n2 != '0) begin
          nxt = S_F2; rem_n = n2;
        end else if (state != S_F3 && n3 != '0) begin
          nxt = S_F3; rem_n = n3;
        end else begin
`ifdef DICT_LOADER_CHECKSUM_EN
          nxt = S_CHK;
`else
          nxt    = S_DONE;
          req.go = 1'b0;
`endif
        end
      end
`ifdef DICT_LOADER_CHECKSUM_EN
      S_CHK: if (rsp.done) nxt = S_DONE;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      rem    <= '0;
      cnt2   <= '0;
      cnt3   <= '0;
      addr_q <= DICT_BASE_ADDR;
    end else begin
      state <= nxt;
      rem   <= rem_n;
      if (state == S_HDR && rsp.done) begin
        cnt2 <= n2;
        cnt3 <= n3;
      end
      if (req.go) addr_q <= addr_q + 32'd4;
    end
  end

  assign dict1_write_enable = rsp.done && state == S_F1;
  assign dict2_write_enable = rsp.done && state == S_F2;
  assign dict3_write_enable = rsp.done && state == S_F3;
  assign dict1_write_val    = rsp.data[FIELD1_VAL_WIDTH-1:0];
  assign dict2_write_val    = rsp.data[FIELD2_VAL_WIDTH-1:0];
  assign dict3_write_val    = rsp.data[FIELD3_VAL_WIDTH-1:0];
  assign busy               = state != S_IDLE && state != S_DONE;
  assign load_done          = state == S_DONE;

`ifdef DICT_LOADER_CHECKSUM_EN
  logic [31:0] xsum;
  logic        err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      xsum <= '0;
      err  <= 1'b0;
    end else if (rsp.done) begin
      if (state == S_CHK) err <= (rsp.data != xsum);
      else                xsum <= xsum ^ rsp.data;
    end
  end

  assign load_error = err;
`endif

endmodule

// File: tb/tb_dict_loader.sv
// Randomized self-checking bench for dict_loader against a queue-based model
// of the dictionary image; checksum cases compile in with DICT_LOADER_CHECKSUM_EN.
module tb_dict_loader;
  localparam logic [31:0] BASE = 32'h0000_F000;

  logic        clk = 1'b0, resetn, start;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr, mem_req_rdata;
  logic        dict1_write_enable, dict2_write_enable, dict3_write_enable;
  logic [6:0]  dict1_write_val;
  logic [9:0]  dict2_write_val;
  logic [14:0] dict3_write_val;
  logic        busy, load_done;
`ifdef DICT_LOADER_CHECKSUM_EN
  logic        load_error;
`endif

  dict_loader dut (
    .clk(clk), .resetn(resetn), .start(start),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rdata(mem_req_rdata),
    .dict1_write_enable(dict1_write_enable), .dict1_write_val(dict1_write_val),
    .dict2_write_enable(dict2_write_enable), .dict2_write_val(dict2_write_val),
    .dict3_write_enable(dict3_write_enable), .dict3_write_val(dict3_write_val),
    .busy(busy), .load_done(load_done)
`ifdef DICT_LOADER_CHECKSUM_EN
    , .load_error(load_error)
`endif
  );

  initial forever #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // memory image and responder
  logic [31:0] mem [int unsigned];
  int mem_delay = 0, wcnt = 0;
  initial begin
    mem_req_ready = 1'b0; mem_req_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid) begin
        if (wcnt >= mem_delay) begin
          mem_req_ready = 1'b1;
          mem_req_rdata = mem.exists(mem_req_addr) ? mem[mem_req_addr] : $urandom;
          wcnt = 0;
        end else begin
          mem_req_ready = 1'b0; mem_req_rdata = $urandom; wcnt++;
        end
      end else begin
        mem_req_ready = 1'($urandom_range(0, 1)); // must be ignored
        mem_req_rdata = $urandom; wcnt = 0;
      end
    end
  end

  // observed activity
  logic [31:0] w1q[$], w2q[$], w3q[$], rdq[$];
  int runq[$];
  int excl_viol, stab_viol, busy_viol, fv, dc, run;
  bit pv;
  logic [31:0] pa;
  initial forever begin
    @(negedge clk);
    if (dict1_write_enable) w1q.push_back({25'b0, dict1_write_val});
    if (dict2_write_enable) w2q.push_back({22'b0, dict2_write_val});
    if (dict3_write_enable) w3q.push_back({17'b0, dict3_write_val});
    if (int'(dict1_write_enable) + int'(dict2_write_enable) + int'(dict3_write_enable) > 1) excl_viol++;
    if (mem_req_valid) begin
      if (!pv) begin
        rdq.push_back(mem_req_addr); run = 1;
        if (fv < 0) fv = cyc;
      end else begin
        run++;
        if (mem_req_addr != pa) stab_viol++;
      end
    end else if (pv) runq.push_back(run);
    if (load_done && dc < 0) dc = cyc;
    if (fv >= 0 && dc < 0 && !busy) busy_viol++;
    pv = mem_req_valid; pa = mem_req_addr;
  end

  task automatic clear_mon();
    w1q.delete(); w2q.delete(); w3q.delete(); rdq.delete(); runq.delete();
    excl_viol = 0; stab_viol = 0; busy_viol = 0; fv = -1; dc = -1; run = 0; pv = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); resetn = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();
    resetn = 1'b1;
  endtask

  // reference image: expected strobe values, read count, checksum
  logic [31:0] e1[$], e2[$], e3[$];
  int exp_words, cur_dly;
  bit cur_bad;

  task automatic prep_load(input logic [31:0] hdr, input int dly, input bit bad);
    int c1, c2, c3, n;
    logic [31:0] x, w;
    c1 = (int'(hdr[8:0]) > 8) ? 8 : int'(hdr[8:0]);
    c2 = (int'(hdr[17:9]) > 32) ? 32 : int'(hdr[17:9]);
    c3 = (int'(hdr[26:18]) > 256) ? 256 : int'(hdr[26:18]);
    n = c1 + c2 + c3;
    e1.delete(); e2.delete(); e3.delete(); mem.delete();
    mem[BASE] = hdr; x = hdr;
    for (int i = 0; i < n + 4; i++) begin
      w = $urandom;
      mem[BASE + 32'(4 * (1 + i))] = w;
      if (i < n) begin
        x ^= w;
        if (i < c1)           e1.push_back({25'b0, w[6:0]});
        else if (i < c1 + c2) e2.push_back({22'b0, w[9:0]});
        else                  e3.push_back({17'b0, w[14:0]});
      end
    end
    exp_words = 1 + n;
`ifdef DICT_LOADER_CHECKSUM_EN
    mem[BASE + 32'(4 * (1 + n))] = bad ? (x ^ (32'h1 << $urandom_range(0, 31))) : x;
    exp_words++;
`endif
    cur_dly = dly; cur_bad = bad; mem_delay = dly;
  endtask

  task automatic cmp_q(input string nm, input logic [31:0] got[$], input logic [31:0] exp[$]);
    vectors++;
    if (got.size() != exp.size()) begin
      miscompares++;
      $display("FAIL %s count: got %0d expected %0d", nm, got.size(), exp.size());
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %h expected %h", nm, i, got[i], exp[i]);
      end
    end
  endtask

  task automatic run_load(input string nm);
    int tstart, guard;
    logic [31:0] ea[$];
    do_reset();
    @(negedge clk); tstart = cyc; start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (dc < 0 && guard < 20000) begin @(negedge clk); guard++; end
    vectors++;
    if (dc < 0) begin
      miscompares++;
      $display("FAIL %s timeout: load_done never rose within %0d cycles", nm, guard);
      return;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < exp_words; i++) ea.push_back(BASE + 32'(4 * i));
    cmp_q({nm, ".dict1"}, w1q, e1);
    cmp_q({nm, ".dict2"}, w2q, e2);
    cmp_q({nm, ".dict3"}, w3q, e3);
    cmp_q({nm, ".addr"}, rdq, ea);
    vectors++;
    if (fv - tstart != 1) begin miscompares++; $display("FAIL %s first_req: got %0d expected 1", nm, fv - tstart); end
    vectors++;
    if (dc - tstart != 1 + (cur_dly + 2) * exp_words) begin
      miscompares++; $display("FAIL %s latency: got %0d expected %0d", nm, dc - tstart, 1 + (cur_dly + 2) * exp_words);
    end
    foreach (runq[i]) begin
      vectors++;
      if (runq[i] != cur_dly + 1) begin miscompares++; $display("FAIL %s valid_run[%0d]: got %0d expected %0d", nm, i, runq[i], cur_dly + 1); end
    end
    vectors++;
    if (excl_viol + stab_viol + busy_viol != 0) begin
      miscompares++; $display("FAIL %s protocol: excl %0d stab %0d busy %0d expected 0", nm, excl_viol, stab_viol, busy_viol);
    end
    vectors++;
    if ({busy, load_done} !== 2'b01) begin miscompares++; $display("FAIL %s done_state: got %b expected 01", nm, {busy, load_done}); end
`ifdef DICT_LOADER_CHECKSUM_EN
    vectors++;
    if (load_error !== cur_bad) begin miscompares++; $display("FAIL %s load_error: got %b expected %b", nm, load_error, cur_bad); end
`endif
  endtask

  function automatic logic [31:0] mk_hdr(input int c1, input int c2, input int c3);
    logic [31:0] h;
    h = $urandom;
    h[8:0] = 9'(c1); h[17:9] = 9'(c2); h[26:18] = 9'(c3);
    return h;
  endfunction

  task automatic chk_zero(input string nm);
    vectors++;
    if ({mem_req_valid, mem_req_addr, dict1_write_enable, dict1_write_val, dict2_write_enable,
         dict2_write_val, dict3_write_enable, dict3_write_val, busy, load_done} !== '0) begin
      miscompares++;
      $display("FAIL %s outputs: valid %b addr %h en %b%b%b busy %b done %b expected all 0", nm, mem_req_valid,
               mem_req_addr, dict1_write_enable, dict2_write_enable, dict3_write_enable, busy, load_done);
    end
`ifdef DICT_LOADER_CHECKSUM_EN
    vectors++;
    if (load_error !== 1'b0) begin miscompares++; $display("FAIL %s load_error: got %b expected 0", nm, load_error); end
`endif
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
  endtask

  task automatic test_basic();
    prep_load(mk_hdr(2, 3, 1), 0, 1'b0); run_load("basic_2_3_1");
  endtask

  task automatic test_zero_counts();
    prep_load(mk_hdr(0, 0, 4), 0, 1'b0); run_load("zero_0_0_4");
    prep_load(mk_hdr(0, 0, 0), 0, 1'b0); run_load("zero_all");
    prep_load(mk_hdr(3, 0, 0), 1, 1'b0); run_load("zero_3_0_0");
  endtask

  task automatic test_clamp();
    prep_load(mk_hdr(20, 2, 1), 0, 1'b0); run_load("clamp_c1");
    vectors++;
    if (rdq.size() < 10 || rdq[9] !== BASE + 32'd36) begin
      miscompares++; $display("FAIL clamp_f2_addr: got %h expected %h", (rdq.size() < 10) ? 32'hx : rdq[9], BASE + 32'd36);
    end
    prep_load(mk_hdr(1, 40, 300), 0, 1'b0); run_load("clamp_c2_c3");
  endtask

  task automatic test_wait();
    prep_load(mk_hdr(2, 3, 1), 3, 1'b0); run_load("wait3");
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++)
      begin
        prep_load(mk_hdr($urandom_range(0, 12), $urandom_range(0, 40), $urandom_range(0, 20)),
                  $urandom_range(0, 2), 1'b0);
        run_load($sformatf("rand%0d", i));
      end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    prep_load(mk_hdr(3, 5, 2), 1, 1'b0);
    do_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (w2q.size() < 2 && guard < 500) begin @(negedge clk); guard++; end
    vectors++;
    if (w2q.size() < 2) begin miscompares++; $display("FAIL mid_reset reach_f2: got %0d strobes expected 2", w2q.size()); end
    #2 resetn = 1'b0;
    #1 chk_zero("mid_reset");
    prep_load(mk_hdr(3, 5, 2), 0, 1'b0); run_load("after_reset");
  endtask

  task automatic test_start_ignored();
    int n0;
    prep_load(mk_hdr(1, 1, 1), 0, 1'b0); run_load("pre_restart");
    n0 = rdq.size();
    start = 1'b1; repeat (6) @(negedge clk); start = 1'b0;
    vectors++;
    if (rdq.size() != n0 || load_done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL start_in_done: reads %0d expected %0d done %b busy %b", rdq.size(), n0, load_done, busy);
    end
  endtask

`ifdef DICT_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    prep_load(mk_hdr(2, 3, 1), 0, 1'b1); run_load("chk_bad");
    prep_load(mk_hdr(2, 3, 1), 0, 1'b0); run_load("chk_good");
    prep_load(mk_hdr(0, 0, 0), 1, 1'b1); run_load("chk_bad_empty");
  endtask
`endif

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_zero_counts();
    test_clamp();
    test_wait();
    test_random();
    test_mid_reset();
    test_start_ignored();
`ifdef DICT_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
